// File: rtl/sequenciador_pkg.sv
// Shared widths, FSM state encoding and the symbol-code step helper for sequenciador_display.
// Build option APAGAMENTO_EN adds the APAGANDO blanking state to the encoding.
package sequenciador_pkg;

   localparam int CODE_W   = 2;
   localparam int ESTADO_W = 2;

   typedef logic [CODE_W-1:0] codigo_t;

   typedef enum logic [ESTADO_W-1:0] {
      OCIOSO    = 2'd0,
      EXIBINDO  = 2'd1,
      CONCLUIDO = 2'd2
`ifdef APAGAMENTO_EN
      ,
      APAGANDO  = 2'd3
`endif
   } estado_t;

   // Next symbol in the message; wraps to 0 after the last symbol.
   function automatic codigo_t proximo_codigo(input codigo_t atual, input codigo_t ultimo);
      return (atual == ultimo) ? '0 : codigo_t'(atual + codigo_t'(1));
   endfunction

endpackage

// File: rtl/divisor_tick.sv
// Prescaler: counts 0..DIV_TICKS-1 while enabled and pulses tick_o on the last count.
// clr_i holds the count at 0; DIV_TICKS=1 ticks on every enabled cycle.
module divisor_tick #(
   parameter int DIV_TICKS = 4
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int               CNT_W  = (DIV_TICKS > 1) ? $clog2(DIV_TICKS) : 1;
   localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(DIV_TICKS - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick_o = en_i && (cnt_q == ULTIMO);

   // NOTE: next-state defaults are assigned first so every path drives cnt_d and no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sequenciador_display.sv
// Steps the 2-bit letter code for the seven-segment decoders, one-shot or cyclic, with a done/ack handshake.
// Build option APAGAMENTO_EN inserts APAGA_TICKS blank cycles after each symbol.
module sequenciador_display
   import sequenciador_pkg::*;
#(
   parameter int DIV_TICKS   = 4,
   parameter int N_SIMBOLOS  = 4,
   parameter int APAGA_TICKS = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic iniciar,
   input  logic parar,
   input  logic ciclico,
   input  logic reconhecer,
   output logic saida1Contador,
   output logic saida2Contador,
   output logic ativo,
   output logic concluido,
   output logic apagar
);

   if (DIV_TICKS < 1 || N_SIMBOLOS < 1 || N_SIMBOLOS > 4 || APAGA_TICKS < 1) begin : g_param_invalido
      $error("sequenciador_display: parameter out of range");
   end

   localparam codigo_t ULTIMO = codigo_t'(N_SIMBOLOS - 1);

   estado_t state_q;
   estado_t state_d;
   codigo_t code_q;
   codigo_t code_d;
   logic    ciclico_q;
   logic    ciclico_d;
   logic    div_en;
   logic    div_clr;
   logic    tick;

`ifdef APAGAMENTO_EN
   localparam int                 APAGA_W      = (APAGA_TICKS > 1) ? $clog2(APAGA_TICKS) : 1;
   localparam logic [APAGA_W-1:0] APAGA_ULTIMO = APAGA_W'(APAGA_TICKS - 1);

   logic [APAGA_W-1:0] apaga_q;
   logic [APAGA_W-1:0] apaga_d;
`endif

   // The prescaler only runs while a symbol is on display, so it restarts from 0 after any pause.
   assign div_en  = (state_q == EXIBINDO);
   assign div_clr = !div_en;

   divisor_tick #(
      .DIV_TICKS(DIV_TICKS)
   ) u_divisor (
      .clock_i(clock),
      .reset_i(reset),
      .clr_i  (div_clr),
      .en_i   (div_en),
      .tick_o (tick)
   );

   always_comb begin
      state_d   = state_q;
      code_d    = code_q;
      ciclico_d = ciclico_q;
`ifdef APAGAMENTO_EN
      apaga_d   = apaga_q;
`endif
      case (state_q)
         OCIOSO: begin
            code_d = '0;
            if (iniciar && !parar) begin
               state_d   = EXIBINDO;
               ciclico_d = ciclico;
            end
         end
         EXIBINDO: begin
            if (parar) begin
               state_d = OCIOSO;
               code_d  = '0;
            end else if (tick) begin
               if (code_q == ULTIMO && !ciclico_q) begin
                  state_d = CONCLUIDO;
               end else begin
`ifdef APAGAMENTO_EN
                  state_d = APAGANDO;
                  apaga_d = '0;
`else
                  code_d  = proximo_codigo(code_q, ULTIMO);
`endif
               end
            end
         end
`ifdef APAGAMENTO_EN
         APAGANDO: begin
            // The code steps only when the blank ends, so the blanked symbol stays on the bus.
            if (parar) begin
               state_d = OCIOSO;
               code_d  = '0;
            end else if (apaga_q == APAGA_ULTIMO) begin
               state_d = EXIBINDO;
               code_d  = proximo_codigo(code_q, ULTIMO);
            end else begin
               apaga_d = apaga_q + APAGA_W'(1);
            end
         end
`endif
         CONCLUIDO: begin
            if (parar || reconhecer) begin
               state_d = OCIOSO;
               code_d  = '0;
            end
         end
         default: begin
            state_d = OCIOSO;
            code_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= OCIOSO;
         code_q    <= '0;
         ciclico_q <= 1'b0;
`ifdef APAGAMENTO_EN
         apaga_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         code_q    <= code_d;
         ciclico_q <= ciclico_d;
`ifdef APAGAMENTO_EN
         apaga_q   <= apaga_d;
`endif
      end
   end

   assign saida1Contador = code_q[1];
   assign saida2Contador = code_q[0];
   assign concluido      = (state_q == CONCLUIDO);

`ifdef APAGAMENTO_EN
   assign ativo  = (state_q == EXIBINDO) || (state_q == APAGANDO);
   assign apagar = (state_q == APAGANDO);
`else
   assign ativo  = (state_q == EXIBINDO);
   assign apagar = 1'b0;
`endif

endmodule

// File: tb/tb_sequenciador_display.sv
// Bench for sequenciador_display: timeline model (elapsed cycles -> symbol/blank) checked every cycle,
// directed scenarios with literal expectations, then randomized control inputs.
module tb_sequenciador_display;

   localparam int DIV = 4;
   localparam int NS  = 3;
   localparam int APG = 2;
`ifdef APAGAMENTO_EN
   localparam int BLANK = APG;
`else
   localparam int BLANK = 0;
`endif
   localparam int P         = DIV + BLANK;
   localparam int ATIVO_LEN = (NS - 1) * P + DIV;

   logic clock      = 1'b0;
   logic reset      = 1'b1;
   logic iniciar    = 1'b0;
   logic parar      = 1'b0;
   logic ciclico    = 1'b0;
   logic reconhecer = 1'b0;
   logic s1, s2, ativo, concluido, apagar;

   sequenciador_display #(
      .DIV_TICKS  (DIV),
      .N_SIMBOLOS (NS),
      .APAGA_TICKS(APG)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .iniciar       (iniciar),
      .parar         (parar),
      .ciclico       (ciclico),
      .reconhecer    (reconhecer),
      .saida1Contador(s1),
      .saida2Contador(s2),
      .ativo         (ativo),
      .concluido     (concluido),
      .apagar        (apagar)
   );

   always #5 clock = ~clock;

   // Model: idle / running for t cycles since start / finished awaiting ack.
   typedef enum {M_IDLE, M_RUN, M_DONE} modo_t;
   modo_t modo   = M_IDLE;
   int    t      = 0;
   bit    cyc    = 1'b0;
   int    n_pass   = 0;
   int    n_checks = 0;
   bit    chk_en   = 1'b0;
   int    c        = 0;

   always @(posedge clock) begin
      if (reset) begin
         modo <= M_IDLE;
      end else begin
         case (modo)
            M_IDLE: if (iniciar && !parar) begin
               modo <= M_RUN;
               t    <= 1;
               cyc  <= ciclico;
            end
            M_RUN: if (parar) begin
               modo <= M_IDLE;
            end else begin
               t <= t + 1;
               if (!cyc && (t + 1) > ATIVO_LEN) modo <= M_DONE;
            end
            M_DONE: if (parar || reconhecer) modo <= M_IDLE;
            default: modo <= M_IDLE;
         endcase
      end
   end

   // Expected {code[1:0], ativo, concluido, apagar} from the timeline position.
   function automatic logic [4:0] esperado();
      int k;
      int r;
      logic [4:0] e;
      e = '0;
      case (modo)
         M_RUN: begin
            k      = (t - 1) / P;
            r      = (t - 1) % P;
            e[4:3] = 2'(cyc ? (k % NS) : k);
            e[2]   = 1'b1;
            e[0]   = (r >= DIV);
         end
         M_DONE: begin
            e[4:3] = 2'(NS - 1);
            e[1]   = 1'b1;
         end
         default: e = '0;
      endcase
      return e;
   endfunction

   function automatic logic [4:0] saidas();
      return {s1, s2, ativo, concluido, apagar};
   endfunction

   task automatic check(input string nome, input logic [4:0] got, input logic [4:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b (code,ativo,concluido,apagar) at %0t", nome, got, exp, $time);
   endtask

   always @(negedge clock) begin
      if (chk_en) check("modelo", saidas(), esperado());
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(negedge clock);
         c++;
      end
   endtask

   task automatic ate(input int alvo);
      if (alvo > c) step(alvo - c);
   endtask

   task automatic arranca(input bit cic);
      iniciar = 1'b1;
      ciclico = cic;
      c       = 0;
      step();
      iniciar = 1'b0;
   endtask

   task automatic para();
      parar = 1'b1;
      step();
      parar = 1'b0;
      step();
   endtask

   initial begin
      step(3);
      reset  = 1'b0;
      chk_en = 1'b1;
      check("reset", saidas(), 5'b00000);
      step();

      // One-shot run with ack.
      arranca(1'b0);
      check("t2_c1", saidas(), 5'b00100);
`ifdef APAGAMENTO_EN
      ate(5);  check("t6_c5", saidas(), 5'b00101);
      ate(6);  check("t6_c6", saidas(), 5'b00101);
      ate(7);  check("t6_c7", saidas(), 5'b01100);
      ate(11); check("t6_c11", saidas(), 5'b01101);
      ate(13); check("t6_c13", saidas(), 5'b10100);
      ate(16); check("t6_c16", saidas(), 5'b10100);
      ate(17); check("t6_c17", saidas(), 5'b10010);
      ate(19);
      reconhecer = 1'b1;
      step();
      reconhecer = 1'b0;
      check("t6_ack", saidas(), 5'b00000);
`else
      ate(4);  check("t2_c4", saidas(), 5'b00100);
      ate(5);  check("t2_c5", saidas(), 5'b01100);
      ate(9);  check("t2_c9", saidas(), 5'b10100);
      ate(12); check("t2_c12", saidas(), 5'b10100);
      ate(13); check("t2_c13", saidas(), 5'b10010);
      ate(15);
      reconhecer = 1'b1;
      step();
      reconhecer = 1'b0;
      check("t2_c16", saidas(), 5'b00000);
`endif
      step();

      // Cyclic run, 30 cycles, then abort.
      arranca(1'b1);
`ifdef APAGAMENTO_EN
      ate(19); check("t3_wrap", saidas(), 5'b00100);
      ate(23); check("t3_blank", saidas(), 5'b00101);
`else
      ate(13); check("t3_wrap", saidas(), 5'b00100);
      ate(17); check("t3_c17", saidas(), 5'b01100);
`endif
      ate(30);
      parar = 1'b1;
      step();
      parar = 1'b0;
      check("t3_parar", saidas(), 5'b00000);
      step();

      // Abort on the same cycle as a tick.
      arranca(1'b0);
      ate(4);
      parar = 1'b1;
      step();
      parar = 1'b0;
      check("t4_tick_parar", saidas(), 5'b00000);
      step();

      // iniciar+parar in idle, then iniciar during display.
      iniciar = 1'b1;
      parar   = 1'b1;
      step();
      iniciar = 1'b0;
      parar   = 1'b0;
      check("t5_parar_vence", saidas(), 5'b00000);
      arranca(1'b0);
      ate(2);
      iniciar = 1'b1;
      step();
      iniciar = 1'b0;
      ate(7);
      check("t5_sem_reinicio", saidas(), 5'b01100);
      para();

      // Reset held 3 cycles mid-display.
      arranca(1'b0);
      ate(6);
      reset = 1'b1;
      step(3);
      reset = 1'b0;
      check("t1_reset", saidas(), 5'b00000);
      step();

      // Randomized control inputs against the timeline model.
      for (int i = 0; i < 3000; i++) begin
         reset      = ($urandom_range(0, 299) == 0);
         iniciar    = ($urandom_range(0, 3) == 0);
         parar      = ($urandom_range(0, 24) == 0);
         reconhecer = ($urandom_range(0, 3) == 0);
         ciclico    = 1'($urandom_range(0, 1));
         step();
      end
      reset   = 1'b0;
      iniciar = 1'b0;
      parar   = 1'b0;
      step(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
